// File: rtl/regbank_write_arbiter_if.sv
// Writeback bundle between the three requesters / register bank and regbank_write_arbiter.
// The requester and bank side uses the master modport; the arbiter uses slave.
interface regbank_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              mul_valid;
  logic              mul_ready;
  logic [DATA_W-1:0] mul_hi;
  logic [DATA_W-1:0] mul_lo;
  logic              lnk_valid;
  logic              lnk_ready;
  logic [DATA_W-1:0] lnk_data;
  logic [1:0]        rb_reg_write;
  logic [ADDR_W-1:0] rb_write_add;
  logic [DATA_W-1:0] rb_write_data;
  logic [DATA_W-1:0] rb_high_data;
  logic [DATA_W-1:0] rb_ra_data;
  logic [31:0]       pending_mask;
  logic [1:0]        grant_id;

  modport master (
    output alu_valid, alu_addr, alu_data, mul_valid, mul_hi, mul_lo, lnk_valid, lnk_data,
    input  alu_ready, mul_ready, lnk_ready, rb_reg_write, rb_write_add, rb_write_data,
           rb_high_data, rb_ra_data, pending_mask, grant_id
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, mul_valid, mul_hi, mul_lo, lnk_valid, lnk_data,
    output alu_ready, mul_ready, lnk_ready, rb_reg_write, rb_write_add, rb_write_data,
           rb_high_data, rb_ra_data, pending_mask, grant_id
  );
endinterface

// File: rtl/regbank_write_arbiter.sv
// Arbitrates ALU / MUL / LNK writebacks onto the single register-bank write port.
// Optional REGARB_STATS_EN adds stat_conflicts_o, a saturating count of contended cycles.
module regbank_write_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4,
  parameter int HI_REG       = 19,
  parameter int LO_REG       = 20,
  parameter int RA_REG       = 31
) (
  input  logic                   clk,
  input  logic                   rst,
  regbank_write_arbiter_if.slave bus
`ifdef REGARB_STATS_EN
  ,
  output logic [15:0]            stat_conflicts_o
`endif
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  // Grant codes double as the bank write-mode encoding.
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_ALU  = 2'b01;
  localparam logic [1:0] GNT_MUL  = 2'b10;
  localparam logic [1:0] GNT_LNK  = 2'b11;

  function automatic logic [CNT_W-1:0] wait_next(input logic full, input logic granted,
                                                 input logic [CNT_W-1:0] cnt);
    if (full && !granted) begin
      return (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
    end else begin
      return '0;
    end
  endfunction

  logic              alu_full_q, alu_full_d, mul_full_q, mul_full_d, lnk_full_q, lnk_full_d;
  logic [ADDR_W-1:0] alu_addr_q, alu_addr_d;
  logic [DATA_W-1:0] alu_data_q, alu_data_d, mul_hi_q, mul_hi_d, mul_lo_q, mul_lo_d;
  logic [DATA_W-1:0] lnk_data_q, lnk_data_d;
  logic [CNT_W-1:0]  alu_wait_q, alu_wait_d, mul_wait_q, mul_wait_d, lnk_wait_q, lnk_wait_d;
  logic [1:0]        gnt_s;
  logic              alu_gnt_s, mul_gnt_s, lnk_gnt_s;
  logic              alu_ready_s, mul_ready_s, lnk_ready_s;

  // Grant selection: starved requesters (ALU > MUL > LNK) beat normal priority (LNK > MUL > ALU).
  always_comb begin
    gnt_s = GNT_NONE;
    if (alu_full_q && alu_wait_q == CNT_MAX) begin
      gnt_s = GNT_ALU;
    end else if (mul_full_q && mul_wait_q == CNT_MAX) begin
      gnt_s = GNT_MUL;
    end else if (lnk_full_q && lnk_wait_q == CNT_MAX) begin
      gnt_s = GNT_LNK;
    end else if (lnk_full_q) begin
      gnt_s = GNT_LNK;
    end else if (mul_full_q) begin
      gnt_s = GNT_MUL;
    end else if (alu_full_q) begin
      gnt_s = GNT_ALU;
    end else begin
      gnt_s = GNT_NONE;
    end
  end

  assign alu_gnt_s   = (gnt_s == GNT_ALU);
  assign mul_gnt_s   = (gnt_s == GNT_MUL);
  assign lnk_gnt_s   = (gnt_s == GNT_LNK);
  assign alu_ready_s = ~alu_full_q | alu_gnt_s;
  assign mul_ready_s = ~mul_full_q | mul_gnt_s;
  assign lnk_ready_s = ~lnk_full_q | lnk_gnt_s;
  assign bus.alu_ready = alu_ready_s;
  assign bus.mul_ready = mul_ready_s;
  assign bus.lnk_ready = lnk_ready_s;

  // Bank-side outputs from the granted buffer; unused fields forced to zero.
  always_comb begin
    bus.rb_reg_write  = gnt_s;
    bus.grant_id      = gnt_s;
    bus.rb_write_add  = '0;
    bus.rb_write_data = '0;
    bus.rb_high_data  = '0;
    bus.rb_ra_data    = '0;
    case (gnt_s)
      GNT_ALU: begin
        bus.rb_write_add  = alu_addr_q;
        bus.rb_write_data = alu_data_q;
      end
      GNT_MUL: begin
        bus.rb_write_data = mul_lo_q;
        bus.rb_high_data  = mul_hi_q;
      end
      GNT_LNK: bus.rb_ra_data = lnk_data_q;
      default: bus.rb_write_add = '0;
    endcase
  end

  // Pending-write scoreboard; a full ALU buffer never holds R0, but bit 0 is cleared regardless.
  always_comb begin
    bus.pending_mask = ({32{alu_full_q}} & (32'd1 << alu_addr_q))
                     | ({32{mul_full_q}} & ((32'd1 << HI_REG) | (32'd1 << LO_REG)))
                     | ({32{lnk_full_q}} & (32'd1 << RA_REG));
    bus.pending_mask[0] = 1'b0;
  end

  // Buffer next state: a load wins over the clear of a granted entry; R0 writes are dropped.
  always_comb begin
    alu_addr_d = alu_addr_q;
    alu_data_d = alu_data_q;
    mul_hi_d   = mul_hi_q;
    mul_lo_d   = mul_lo_q;
    lnk_data_d = lnk_data_q;
    if (bus.alu_valid && alu_ready_s) begin
      alu_full_d = (bus.alu_addr != '0);
      alu_addr_d = bus.alu_addr;
      alu_data_d = bus.alu_data;
    end else if (alu_gnt_s) begin
      alu_full_d = 1'b0;
    end else begin
      alu_full_d = alu_full_q;
    end
    if (bus.mul_valid && mul_ready_s) begin
      mul_full_d = 1'b1;
      mul_hi_d   = bus.mul_hi;
      mul_lo_d   = bus.mul_lo;
    end else if (mul_gnt_s) begin
      mul_full_d = 1'b0;
    end else begin
      mul_full_d = mul_full_q;
    end
    if (bus.lnk_valid && lnk_ready_s) begin
      lnk_full_d = 1'b1;
      lnk_data_d = bus.lnk_data;
    end else if (lnk_gnt_s) begin
      lnk_full_d = 1'b0;
    end else begin
      lnk_full_d = lnk_full_q;
    end
    alu_wait_d = wait_next(alu_full_q, alu_gnt_s, alu_wait_q);
    mul_wait_d = wait_next(mul_full_q, mul_gnt_s, mul_wait_q);
    lnk_wait_d = wait_next(lnk_full_q, lnk_gnt_s, lnk_wait_q);
  end

  // Buffer and wait-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_full_q <= 1'b0;
      mul_full_q <= 1'b0;
      lnk_full_q <= 1'b0;
      alu_addr_q <= '0;
      alu_data_q <= '0;
      mul_hi_q   <= '0;
      mul_lo_q   <= '0;
      lnk_data_q <= '0;
      alu_wait_q <= '0;
      mul_wait_q <= '0;
      lnk_wait_q <= '0;
    end else begin
      alu_full_q <= alu_full_d;
      mul_full_q <= mul_full_d;
      lnk_full_q <= lnk_full_d;
      alu_addr_q <= alu_addr_d;
      alu_data_q <= alu_data_d;
      mul_hi_q   <= mul_hi_d;
      mul_lo_q   <= mul_lo_d;
      lnk_data_q <= lnk_data_d;
      alu_wait_q <= alu_wait_d;
      mul_wait_q <= mul_wait_d;
      lnk_wait_q <= lnk_wait_d;
    end
  end

`ifdef REGARB_STATS_EN
  logic [15:0] stat_q, stat_d;
  logic        conflict_s;

  // Saturating count of cycles with two or more buffers occupied.
  always_comb begin
    conflict_s = (alu_full_q & mul_full_q) | (alu_full_q & lnk_full_q) | (mul_full_q & lnk_full_q);
    if (conflict_s && stat_q != 16'hFFFF) begin
      stat_d = stat_q + 16'd1;
    end else begin
      stat_d = stat_q;
    end
  end

  // Conflict statistics register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_q <= 16'd0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_conflicts_o = stat_q;
`endif

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed scoreboard bench for regbank_write_arbiter: expected bank outputs are queued
// as stimulus is driven and compared at the following falling edge.
module tb_regbank_write_arbiter;

  typedef struct packed {
    logic [1:0]  mode;
    logic [1:0]  gid;
    logic [4:0]  add;
    logic [31:0] wdata;
    logic [31:0] hdata;
    logic [31:0] radata;
    logic [31:0] mask;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  regbank_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

`ifdef REGARB_STATS_EN
  logic [15:0] stat_conflicts;
`endif

  regbank_write_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef REGARB_STATS_EN
    ,
    .stat_conflicts_o (stat_conflicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] gid, input logic [4:0] add, input logic [31:0] wd,
                      input logic [31:0] hd, input logic [31:0] ra, input logic [31:0] mask);
    exp_t e;
    e.mode = gid; e.gid = gid; e.add = add;
    e.wdata = wd; e.hdata = hd; e.radata = ra; e.mask = mask;
    sb.push_back(e);
  endtask

  task automatic push_idle(input logic [31:0] mask);
    push(2'b00, 5'd0, 32'd0, 32'd0, 32'd0, mask);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("rb_reg_write",  {30'd0, bus.rb_reg_write}, {30'd0, e.mode});
      chk("grant_id",      {30'd0, bus.grant_id},     {30'd0, e.gid});
      chk("rb_write_add",  {27'd0, bus.rb_write_add}, {27'd0, e.add});
      chk("rb_write_data", bus.rb_write_data, e.wdata);
      chk("rb_high_data",  bus.rb_high_data,  e.hdata);
      chk("rb_ra_data",    bus.rb_ra_data,    e.radata);
      chk("pending_mask",  bus.pending_mask,  e.mask);
    end
  endtask

  task automatic check_ready(input logic a, input logic m, input logic l);
    chk("alu_ready", {31'd0, bus.alu_ready}, {31'd0, a});
    chk("mul_ready", {31'd0, bus.mul_ready}, {31'd0, m});
    chk("lnk_ready", {31'd0, bus.lnk_ready}, {31'd0, l});
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  initial begin
    bus.alu_valid = 1'b0; bus.alu_addr = 5'd0; bus.alu_data = 32'd0;
    bus.mul_valid = 1'b0; bus.mul_hi = 32'd0;  bus.mul_lo = 32'd0;
    bus.lnk_valid = 1'b0; bus.lnk_data = 32'd0;

    // Reset state
    @(negedge clk);
    push_idle(32'd0);
    check_out();
    check_ready(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    push_idle(32'd0);
    step();

    // Single ALU write, then idle
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd9; bus.alu_data = 32'h1234;
    push(2'b01, 5'd9, 32'h1234, 32'd0, 32'd0, 32'h0000_0200);
    step();
    bus.alu_valid = 1'b0;
    push_idle(32'd0);
    step();

    // Simultaneous requests: LNK, MUL, ALU in that order
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd5; bus.alu_data = 32'hA;
    bus.mul_valid = 1'b1; bus.mul_hi = 32'h1;  bus.mul_lo = 32'h2;
    bus.lnk_valid = 1'b1; bus.lnk_data = 32'h40;
    push(2'b11, 5'd0, 32'd0, 32'd0, 32'h40, 32'h8018_0020);
    step();
    bus.alu_valid = 1'b0; bus.mul_valid = 1'b0; bus.lnk_valid = 1'b0;
    push(2'b10, 5'd0, 32'h2, 32'h1, 32'd0, 32'h0018_0020);
    step();
    push(2'b01, 5'd5, 32'hA, 32'd0, 32'd0, 32'h0000_0020);
    step();
    push_idle(32'd0);
    step();

    // Starvation: LNK re-requests every cycle, ALU wins after 4 losses, then starved MUL
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd3; bus.alu_data = 32'h33;
    bus.mul_valid = 1'b1; bus.mul_hi = 32'hA1; bus.mul_lo = 32'hB1;
    bus.lnk_valid = 1'b1; bus.lnk_data = 32'hC1;
    push(2'b11, 5'd0, 32'd0, 32'd0, 32'hC1, 32'h8018_0008);
    step();
    bus.alu_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(2'b11, 5'd0, 32'd0, 32'd0, 32'hC1, 32'h8018_0008);
      step();
    end
    push(2'b01, 5'd3, 32'h33, 32'd0, 32'd0, 32'h8018_0008);
    step();
    check_ready(1'b1, 1'b0, 1'b0);
    bus.mul_valid = 1'b0; bus.lnk_valid = 1'b0;
    push(2'b10, 5'd0, 32'hB1, 32'hA1, 32'd0, 32'h8018_0000);
    step();
    push(2'b11, 5'd0, 32'd0, 32'd0, 32'hC1, 32'h8000_0000);
    step();
    push_idle(32'd0);
    step();

    // Back-to-back ALU writes, ready stays high
    for (int i = 1; i <= 3; i++) begin
      logic [4:0] a;
      a = 5'(i);
      bus.alu_valid = 1'b1; bus.alu_addr = a; bus.alu_data = 32'h11 * i;
      check_ready(1'b1, 1'b1, 1'b1);
      push(2'b01, a, 32'h11 * i, 32'd0, 32'd0, 32'd1 << i);
      step();
    end
    bus.alu_valid = 1'b0;
    push_idle(32'd0);
    step();

    // ALU write to R0 is swallowed
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd0; bus.alu_data = 32'hFFFF;
    check_ready(1'b1, 1'b1, 1'b1);
    push_idle(32'd0);
    step();
    bus.alu_valid = 1'b0;
    push_idle(32'd0);
    step();

    // Reset with all buffers full: outputs clear at once, nothing stale afterwards
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd7; bus.alu_data = 32'h77;
    bus.mul_valid = 1'b1; bus.mul_hi = 32'h5;  bus.mul_lo = 32'h6;
    bus.lnk_valid = 1'b1; bus.lnk_data = 32'h88;
    push(2'b11, 5'd0, 32'd0, 32'd0, 32'h88, 32'h8018_0080);
    step();
    bus.alu_valid = 1'b0; bus.mul_valid = 1'b0; bus.lnk_valid = 1'b0;
    rst = 1'b1;
    #1;
    push_idle(32'd0);
    check_out();
    check_ready(1'b1, 1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_idle(32'd0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/regbank_write_arbiter.md
Name: regbank_write_arbiter

Overview:
Shares the register bank's single write port among three writeback requesters: the ALU result path, the multiplier hi/lo path and the link (jal $ra) path. Each requester has a one-entry holding buffer. The arbiter grants at most one buffered write per cycle and drives the bank's 2-bit write-mode encoding. It also exports a pending-write scoreboard so the decode stage can stall on read-after-write hazards.

Parameters:
DATA_W, 32, data width of every write
ADDR_W, 5, register address width
STARVE_LIMIT, 4, consecutive lost-arbitration cycles before a requester is promoted
HI_REG, 19, register written with multiplier high word
LO_REG, 20, register written with multiplier low word
RA_REG, 31, link register

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
alu_valid  in  1  ALU write request
alu_ready  out  1  ALU buffer can accept
alu_addr  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
mul_valid  in  1  multiplier write request
mul_ready  out  1  multiplier buffer can accept
mul_hi  in  DATA_W  product high word
mul_lo  in  DATA_W  product low word
lnk_valid  in  1  link write request
lnk_ready  out  1  link buffer can accept
lnk_data  in  DATA_W  return address
rb_reg_write  out  2  bank write mode: 00 none, 01 addr write, 10 hi/lo, 11 ra
rb_write_add  out  ADDR_W  bank write address (mode 01)
rb_write_data  out  DATA_W  data (mode 01) or low word (mode 10)
rb_high_data  out  DATA_W  high word (mode 10)
rb_ra_data  out  DATA_W  link data (mode 11)
pending_mask  out  32  bit i set = write to Ri buffered, not yet issued
grant_id  out  2  00 none, 01 ALU, 10 MUL, 11 LNK

Behaviour:
- rst (async): all buffers empty, wait counters 0; all outputs 0 except the readys. All readys = 1 while rst is low after reset.
- Accept: on posedge, when X_valid && X_ready, load X's buffer and set it full. The same edge may accept all three requesters.
- X_ready = ~full_X | granted_X. grant is a function of registered state only, so there is no combinational path valid -> ready.
- ALU request with alu_addr == 0: accepted (ready honoured), discarded, never issued, never marked pending.
- Grant is combinational from buffer state. Outputs are driven from the granted buffer in the same cycle. The bank writes at the next posedge, and the buffer clears at that same edge unless it is reloaded at that edge.
- Latency: request accepted at edge E is written into the bank at edge E+1 when uncontested. Throughput is 1 write/cycle.
- Normal priority: LNK > MUL > ALU.
- Wait counters: one per requester, each saturating at STARVE_LIMIT.
  - Increment when the buffer is full and not granted.
  - Clear on grant or when the buffer is empty.
- A requester whose counter == STARVE_LIMIT is starved. Any starved requester beats every non-starved one. Among starved requesters, priority is ALU > MUL > LNK.
- No grant: rb_reg_write = 00, grant_id = 00, all data/address outputs 0.
- Mode outputs per grant:
  - ALU: 01, rb_write_add = addr, rb_write_data = data.
  - MUL: 10, rb_write_data = lo, rb_high_data = hi.
  - LNK: 11, rb_ra_data = data.
  - Unused data outputs are 0.
- pending_mask = OR of:
  - (1 << alu_addr) if the ALU buffer is full
  - bits HI_REG and LO_REG if the MUL buffer is full
  - bit RA_REG if the LNK buffer is full
  - bit 0 is always 0.
- Ordering: FIFO within a requester by construction. No ordering across requesters; the decode stage uses pending_mask.
- Reset mid-operation: buffered writes are dropped, and no partial bank write is issued after rst rises.

Optional Feature:
REGARB_STATS_EN
- Defined: adds output stat_conflicts (16 bits), reset 0. It increments on each cycle with two or more buffers full and saturates at 16'hFFFF.
- Undefined: the port and counter are absent; arbitration is unchanged.

Test Plan:
- Single ALU write: alu_valid, addr 9, data 32'h1234 for one cycle -> next cycle rb_reg_write = 01, rb_write_add = 9, rb_write_data = 32'h1234, pending_mask = 32'h200, grant_id = 01; the following cycle idle with mask 0.
- Simultaneous ALU(5, 0xA), MUL(hi 0x1, lo 0x2), LNK(0x40) accepted at one edge -> grants over the next 3 cycles are LNK (11, ra 0x40), MUL (10, high 0x1, write 0x2), ALU (01, addr 5, 0xA); mask starts 0x80180020.
- Starvation: LNK and MUL each re-requesting every cycle, ALU holds addr 3 -> ALU granted on the 5th cycle after buffering (after 4 losses, STARVE_LIMIT = 4), then its counter clears.
- Back-to-back ALU writes to addrs 1, 2, 3 on consecutive cycles with no contention -> alu_ready stays 1; bank writes on 3 consecutive cycles.
- ALU addr 0 data 0xFFFF -> alu_ready = 1, no grant, pending_mask = 0.
- Assert rst while all three buffers are full -> outputs 0 immediately; after rst falls, no stale write is ever issued.
